nibble_bus_sequencer: RTL and testbench

//   Sequences ownership of a shared 4-bit bidirectional pin group (PMOD ja) for a

---
 rtl/nibble_bus_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_nibble_bus_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_bus_sequencer.sv
// Half-duplex nibble transaction sequencer for a shared 4-bit pin group.
// Phases are drive, turnaround, sample and finish, each one paced in bus slots of CLK_DIV clocks.
module nibble_bus_sequencer #(
    parameter int MAX_NIBBLES = 8,
    parameter int TAR_CYCLES  = 2,
    parameter int CLK_DIV     = 4
) (
    input  logic                     CLK100MHZ,
    input  logic                     reset,
    input  logic                     start,
    input  logic [3:0]               wr_count,
    input  logic [3:0]               rd_count,
    input  logic [4*MAX_NIBBLES-1:0] wr_data,
    output logic                     busy,
    output logic                     done,
    output logic [4*MAX_NIBBLES-1:0] rd_data,
    output logic [3:0]               bus_out,
    output logic                     bus_oe,
    input  logic [3:0]               bus_in
);

    localparam int DW    = 4 * MAX_NIBBLES;
    localparam int CNT_W = $clog2(MAX_NIBBLES + 1);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int TAR_W = $clog2(TAR_CYCLES + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [TAR_W-1:0] TAR_LAST = TAR_W'(TAR_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        TAR,
        SAMPLE,
        FINISH
    } state_t;

    function automatic logic [CNT_W-1:0] sat_count(input logic [3:0] c);
        if (32'(c) > MAX_NIBBLES) begin
            return CNT_W'(MAX_NIBBLES);
        end
        return CNT_W'(c);
    endfunction

    function automatic logic [3:0] nibble_of(input logic [DW-1:0] word,
                                             input logic [CNT_W-1:0] idx);
        logic [DW-1:0] shifted;
        shifted = word >> {idx, 2'b00};
        return shifted[3:0];
    endfunction

    function automatic logic [DW-1:0] place_nibble(input logic [3:0] nib,
                                                   input logic [CNT_W-1:0] idx);
        return {{(DW-4){1'b0}}, nib} << {idx, 2'b00};
    endfunction

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              oe_q, oe_d;
    logic [3:0]        out_q, out_d;
    logic [DW-1:0]     rd_q, rd_d;
    logic [DW-1:0]     wr_data_q, wr_data_d;
    logic [CNT_W-1:0]  wr_n_q, wr_n_d;
    logic [CNT_W-1:0]  rd_n_q, rd_n_d;
    logic [CNT_W-1:0]  nib_q, nib_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [TAR_W-1:0]  tar_q, tar_d;
    logic [3:0]        sync1_q, sync1_d;
    logic [3:0]        sync2_q, sync2_d;
    logic [CNT_W-1:0]  wr_req, rd_req;

    always_comb begin
        wr_req  = sat_count(wr_count);
        rd_req  = sat_count(rd_count);
        sync1_d = bus_in;
        sync2_d = sync1_q;
    end

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        oe_d      = oe_q;
        out_d     = out_q;
        rd_d      = rd_q;
        wr_data_d = wr_data_q;
        wr_n_d    = wr_n_q;
        rd_n_d    = rd_n_q;
        nib_d     = nib_q;
        div_d     = div_q;
        tar_d     = tar_q;

        case (state_q)
            // FINISH still holding busy means the empty transaction path: pulse done now.
            IDLE, FINISH: begin
                state_d = IDLE;
                oe_d    = 1'b0;
                out_d   = 4'h0;
                if (busy_q) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else if (start) begin
                    busy_d    = 1'b1;
                    rd_d      = '0;
                    wr_data_d = wr_data;
                    wr_n_d    = wr_req;
                    rd_n_d    = rd_req;
                    nib_d     = '0;
                    div_d     = '0;
                    tar_d     = '0;
                    if (wr_req != '0) begin
                        state_d = DRIVE;
                        oe_d    = 1'b1;
                        out_d   = wr_data[3:0];
                    end else if (rd_req != '0) begin
                        state_d = TAR;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end

            DRIVE: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (nib_q == wr_n_q - CNT_W'(1)) begin
                        oe_d  = 1'b0;
                        out_d = 4'h0;
                        nib_d = '0;
                        if (rd_n_q != '0) begin
                            state_d = TAR;
                        end else begin
                            state_d = FINISH;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        nib_d = nib_q + CNT_W'(1);
                        out_d = nibble_of(wr_data_q, nib_d);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            TAR: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (tar_q == TAR_LAST) begin
                        state_d = SAMPLE;
                        tar_d   = '0;
                        nib_d   = '0;
                    end else begin
                        tar_d = tar_q + TAR_W'(1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            // Capture on the last clock of each slot, giving the pins the most settling time.
            SAMPLE: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    rd_d  = rd_q | place_nibble(sync2_q, nib_q);
                    if (nib_q == rd_n_q - CNT_W'(1)) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        nib_d = nib_q + CNT_W'(1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                oe_d    = 1'b0;
                out_d   = 4'h0;
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            oe_q    <= 1'b0;
            out_q   <= 4'h0;
            rd_q    <= '0;
            nib_q   <= '0;
            div_q   <= '0;
            tar_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            oe_q    <= oe_d;
            out_q   <= out_d;
            rd_q    <= rd_d;
            nib_q   <= nib_d;
            div_q   <= div_d;
            tar_q   <= tar_d;
        end
    end

    // Latched request data and the pin synchroniser carry no reset.
    always_ff @(posedge CLK100MHZ) begin
        wr_data_q <= wr_data_d;
        wr_n_q    <= wr_n_d;
        rd_n_q    <= rd_n_d;
        sync1_q   <= sync1_d;
        sync2_q   <= sync2_d;
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bus_oe  = oe_q;
    assign bus_out = out_q;
    assign rd_data = rd_q;

endmodule

// File: tb/tb_nibble_bus_sequencer.sv
// Bench for nibble_bus_sequencer: a transaction-level timeline model is checked every cycle,
// with directed scenarios pinned by literal expectations and a randomized transaction phase.
module tb_nibble_bus_sequencer;

    localparam int MAXN = 8;
    localparam int TARC = 2;
    localparam int DIV  = 4;

    logic        CLK100MHZ = 1'b0;
    logic        reset     = 1'b1;
    logic        start     = 1'b0;
    logic [3:0]  wr_count  = 4'h0;
    logic [3:0]  rd_count  = 4'h0;
    logic [31:0] wr_data   = 32'h0;
    logic [3:0]  bus_in    = 4'h0;
    logic        busy, done, bus_oe;
    logic [31:0] rd_data;
    logic [3:0]  bus_out;

    int checks = 0;
    int errors = 0;

    always #5 CLK100MHZ = ~CLK100MHZ;

    nibble_bus_sequencer #(
        .MAX_NIBBLES(MAXN),
        .TAR_CYCLES (TARC),
        .CLK_DIV    (DIV)
    ) dut (
        .CLK100MHZ(CLK100MHZ),
        .reset    (reset),
        .start    (start),
        .wr_count (wr_count),
        .rd_count (rd_count),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .rd_data  (rd_data),
        .bus_out  (bus_out),
        .bus_oe   (bus_oe),
        .bus_in   (bus_in)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int sat(input logic [3:0] c);
        return (int'(c) > MAXN) ? MAXN : int'(c);
    endfunction

    function automatic int spec_latency(input int w, input int r);
        if (w == 0 && r == 0) return 2;
        return 1 + DIV * (w + ((r > 0) ? (TARC + r) : 0));
    endfunction

    // Model: each accepted transaction is a timeline indexed by clocks since acceptance.
    logic [3:0]  hist [0:65535];
    int          cyc = 0;
    bit          mv = 1'b0;
    bit          m_act = 1'b0;
    int          acc, mw, mr;
    logic [31:0] mwd;
    logic        e_busy = 1'b0, e_done = 1'b0, e_oe = 1'b0;
    logic [3:0]  e_out = 4'h0;
    logic [31:0] e_rd = 32'h0;

    initial begin : model
        int t, d, tt, s, endt;
        forever begin
            @(posedge CLK100MHZ);
            cyc++;
            if (cyc < 65536) hist[cyc] = bus_in;
            if (reset) begin
                mv = 1'b1; m_act = 1'b0;
                e_busy = 1'b0; e_done = 1'b0; e_oe = 1'b0; e_out = 4'h0; e_rd = 32'h0;
            end else if (mv) begin
                if (start && !e_busy) begin
                    m_act = 1'b1; acc = cyc;
                    mw = sat(wr_count); mr = sat(rd_count); mwd = wr_data; e_rd = 32'h0;
                end
                e_busy = 1'b0; e_done = 1'b0; e_oe = 1'b0; e_out = 4'h0;
                if (m_act) begin
                    t    = cyc - acc;
                    d    = DIV * mw;
                    tt   = (mr > 0) ? TARC * DIV : 0;
                    s    = DIV * mr;
                    endt = (mw == 0 && mr == 0) ? 1 : d + tt + s;
                    for (int j = 0; j < mr; j++)
                        if (t == d + tt + DIV * (j + 1)) e_rd[4*j +: 4] = hist[cyc-2];
                    e_busy = (t < endt);
                    e_done = (t == endt);
                    if (t < d) begin
                        e_oe  = 1'b1;
                        e_out = mwd[4*(t/DIV) +: 4];
                    end
                    if (t >= endt) m_act = 1'b0;
                end
            end
            #1;
            if (mv) begin
                check($sformatf("busy@%0d", cyc), 32'(busy), 32'(e_busy));
                check($sformatf("done@%0d", cyc), 32'(done), 32'(e_done));
                check($sformatf("bus_oe@%0d", cyc), 32'(bus_oe), 32'(e_oe));
                check($sformatf("bus_out@%0d", cyc), 32'(bus_out), 32'(e_out));
                check($sformatf("rd_data@%0d", cyc), rd_data, e_rd);
            end
        end
    end

    logic [3:0] out_at [0:255];

    // mode 0: random pins, 1: 7 then 3 per read slot (no write phase), 2: constant F.
    task automatic do_txn(input logic [3:0] w, input logic [3:0] r, input logic [31:0] wd,
                          input int mode, input int glitch, output int l, output int oe_n);
        @(negedge CLK100MHZ);
        wr_count = w; rd_count = r; wr_data = wd; start = 1'b1;
        bus_in = (mode == 1) ? 4'h7 : (mode == 2) ? 4'hF : 4'($urandom);
        l = 0; oe_n = 0;
        while (1'b1) begin
            @(posedge CLK100MHZ);
            #2;
            l++;
            if (bus_oe) oe_n++;
            if (l < 256) out_at[l] = bus_out;
            if (done) break;
            if (l >= 200) begin
                checks++; errors++;
                $display("FAIL done_timeout: no done within %0d cycles", l);
                break;
            end
            @(negedge CLK100MHZ);
            start    = (l == glitch);
            wr_count = 4'($urandom);
            rd_count = 4'($urandom);
            wr_data  = $urandom;
            bus_in   = (mode == 1) ? ((l - 1 < 12) ? 4'h7 : 4'h3) :
                       (mode == 2) ? 4'hF : 4'($urandom);
        end
        start = 1'b0;
    endtask

    initial begin : stim
        int lat, oen, w, r, g;
        bit saw_done;

        repeat (3) @(posedge CLK100MHZ);
        #2;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_oe", 32'(bus_oe), 32'd0);
        check("reset_rd", rd_data, 32'h0);
        @(negedge CLK100MHZ);
        reset = 1'b0;

        // Reset during the write phase.
        @(negedge CLK100MHZ);
        wr_count = 4'd4; rd_count = 4'd2; wr_data = 32'h1234_5678; start = 1'b1;
        @(negedge CLK100MHZ);
        start = 1'b0;
        repeat (3) @(negedge CLK100MHZ);
        check("drive_before_rst", 32'(bus_oe), 32'd1);
        reset = 1'b1;
        @(posedge CLK100MHZ);
        #2;
        check("rst_oe", 32'(bus_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        saw_done = 1'b0;
        repeat (2) begin
            @(posedge CLK100MHZ);
            #2;
            if (done) saw_done = 1'b1;
        end
        @(negedge CLK100MHZ);
        reset = 1'b0;
        repeat (4) begin
            @(posedge CLK100MHZ);
            #2;
            if (done) saw_done = 1'b1;
        end
        check("rst_no_done", 32'(saw_done), 32'd0);
        check("rst_rd", rd_data, 32'h0);

        // Write only.
        do_txn(4'd3, 4'd0, 32'h0000_0A5C, 0, 0, lat, oen);
        check("t2_latency", 32'(lat), 32'd13);
        check("t2_nib0", 32'(out_at[1]), 32'hC);
        check("t2_nib0_hold", 32'(out_at[4]), 32'hC);
        check("t2_nib1", 32'(out_at[5]), 32'h5);
        check("t2_nib2", 32'(out_at[9]), 32'hA);
        check("t2_oe_cycles", 32'(oen), 32'd12);

        // Read only.
        do_txn(4'd0, 4'd2, 32'hFFFF_FFFF, 1, 0, lat, oen);
        check("t3_latency", 32'(lat), 32'd17);
        check("t3_rd", rd_data, 32'h0000_0037);
        check("t3_oe_cycles", 32'(oen), 32'd0);

        // Write then read.
        do_txn(4'd2, 4'd1, 32'h0000_0021, 2, 0, lat, oen);
        check("t4_latency", 32'(lat), 32'd21);
        check("t4_rd", rd_data, 32'h0000_000F);
        check("t4_oe_cycles", 32'(oen), 32'd8);

        // Saturating write count.
        do_txn(4'd12, 4'd0, 32'h89AB_CDEF, 0, 0, lat, oen);
        check("t5_latency", 32'(lat), 32'd33);
        check("t5_oe_cycles", 32'(oen), 32'd32);

        // Extra start while busy is ignored.
        do_txn(4'd2, 4'd2, 32'h0000_00B4, 0, 3, lat, oen);
        check("t6_latency", 32'(lat), 32'd25);

        // Start the cycle after done.
        @(posedge CLK100MHZ);
        do_txn(4'd1, 4'd0, 32'h0000_0009, 0, 0, lat, oen);
        check("t7_latency", 32'(lat), 32'd5);
        check("t7_nib0", 32'(out_at[1]), 32'h9);

        // Empty transaction.
        do_txn(4'd0, 4'd0, 32'h0, 0, 0, lat, oen);
        check("t8_latency", 32'(lat), 32'd2);
        check("t8_oe_cycles", 32'(oen), 32'd0);

        // Randomized transactions, including back-to-back starts.
        repeat (60) begin
            repeat ($urandom_range(0, 3)) @(negedge CLK100MHZ);
            w = $urandom_range(0, 15);
            r = $urandom_range(0, 15);
            g = (w + r > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(2, 4) : 0;
            do_txn(4'(w), 4'(r), $urandom, 0, g, lat, oen);
            check("rand_latency", 32'(lat), 32'(spec_latency(sat(4'(w)), sat(4'(r)))));
            check("rand_oe_cycles", 32'(oen), 32'(DIV * sat(4'(w))));
        end

        repeat (5) @(posedge CLK100MHZ);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
